// File: rtl/eth_dds_pkg.sv
// Shared DDS packet definitions for the config receiver and the
// read-back transmitter.
package eth_dds_pkg;

  localparam int          DDS_WORD_NUM = 6;
  localparam logic [15:0] DDS_BYTE_NUM = 16'd24;
  localparam logic [15:0] DDS_MAGIC    = 16'hA55A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_SEND,
    ST_WAIT_DONE
  } dds_tx_state_e;

  typedef struct packed {
    logic [3:0]  wave;
    logic [8:0]  amp;
    logic [31:0] freq;
    logic [31:0] min;
    logic [11:0] phase;
  } dds_cfg_t;

endpackage

// File: rtl/eth_send_dds_if.sv
// Bundle between the DDS control side, the read-back transmitter
// and the UDP TX user interface.
interface eth_send_dds_if;

  logic        send_req;
  logic [3:0]  wave_select;
  logic [8:0]  amp_ctl;
  logic [31:0] freq_ctl;
  logic [31:0] min_ctl;
  logic [11:0] phase_ctl;
  logic        tx_req;
  logic        tx_done;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic [31:0] tx_data;
  logic        busy;
  logic        timeout_err;

  modport master (
    input  send_req, wave_select, amp_ctl,
    input  freq_ctl, min_ctl, phase_ctl,
    input  tx_req, tx_done,
    output tx_start_en, tx_byte_num, tx_data,
    output busy, timeout_err
  );

  modport slave (
    output send_req, wave_select, amp_ctl,
    output freq_ctl, min_ctl, phase_ctl,
    output tx_req, tx_done,
    input  tx_start_en, tx_byte_num, tx_data,
    input  busy, timeout_err
  );

endinterface

// File: rtl/eth_send_dds.sv
// Snapshots the live DDS settings and streams them to the UDP TX
// core as a 6-word read-back packet with a sequence trailer.
import eth_dds_pkg::*;

module eth_send_dds #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input logic            eth_tx_clk,
  input logic            rst_n,
  eth_send_dds_if.master bus
);

  localparam logic [2:0] LAST_IDX = 3'(DDS_WORD_NUM - 1);

  dds_tx_state_e state_q, state_d;
  dds_cfg_t      cfg_q, cfg_d;
  logic [15:0]   seq_q, seq_d;
  logic          pend_q, pend_d;
  logic [2:0]    idx_q, idx_d;
  logic [15:0]   wdog_q, wdog_d;
  logic          start_q, start_d;
  logic [15:0]   bytes_q, bytes_d;
  logic [31:0]   data_q, data_d;
  logic          busy_q, busy_d;
  logic          terr_q, terr_d;
  logic          wdog_hit;

  function automatic logic [31:0] word_sel(
    input dds_cfg_t    c,
    input logic [15:0] s,
    input logic [2:0]  i
  );
    logic [31:0] w;
    w = '0;
    case (i)
      3'd0:    w = {28'b0, c.wave};
      3'd1:    w = {23'b0, c.amp};
      3'd2:    w = c.freq;
      3'd3:    w = c.min;
      3'd4:    w = {20'b0, c.phase};
      3'd5:    w = {DDS_MAGIC, s};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign wdog_hit =
    ({1'b0, wdog_q} + 17'd1) >= {1'b0, TIMEOUT_CYC};

  // Next-state, snapshot, sequencing and output register inputs
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
    wdog_d  = wdog_q;
    bytes_d = bytes_q;
    data_d  = data_q;
    start_d = 1'b0;
    terr_d  = 1'b0;
    pend_d  = pend_q |
              (bus.send_req & (state_q != ST_IDLE));
    unique case (state_q)
      ST_IDLE: begin
        if (bus.send_req | pend_q) begin
          cfg_d.wave  = bus.wave_select;
          cfg_d.amp   = bus.amp_ctl;
          cfg_d.freq  = bus.freq_ctl;
          cfg_d.min   = bus.min_ctl;
          cfg_d.phase = bus.phase_ctl;
          pend_d      = 1'b0;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        start_d = 1'b1;
        bytes_d = DDS_BYTE_NUM;
        idx_d   = '0;
        wdog_d  = '0;
        state_d = ST_SEND;
      end
      ST_SEND, ST_WAIT_DONE: begin
        if (bus.tx_done) begin
          seq_d   = seq_q + 16'd1;
          state_d = ST_IDLE;
        end else if (bus.tx_req) begin
          wdog_d = '0;
          if (state_q == ST_SEND) begin
            data_d = word_sel(cfg_q, seq_q, idx_q);
            idx_d  = idx_q + 3'd1;
            if (idx_q == LAST_IDX)
              state_d = ST_WAIT_DONE;
          end else begin
            data_d = '0;
          end
        end else if (wdog_hit) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      seq_q   <= '0;
      pend_q  <= 1'b0;
      idx_q   <= '0;
      wdog_q  <= '0;
      start_q <= 1'b0;
      bytes_q <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      seq_q   <= seq_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      wdog_q  <= wdog_d;
      start_q <= start_d;
      bytes_q <= bytes_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.tx_start_en = start_q;
  assign bus.tx_byte_num = bytes_q;
  assign bus.tx_data     = data_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: doc/eth_send_dds.md
# eth_send_dds

Transmit-side companion of the DDS configuration receiver. It snapshots the live DDS settings and hands them to the UDP transmit core as a fixed 6-word (24-byte) read-back packet, so the host can confirm what the generator is running. It sits between the DDS control registers and the UDP TX user interface in the `eth_tx_clk` domain. The word layout matches the received configuration packet, with a trailer word appended.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 16'd50000: cycles without `tx_req`/`tx_done` progress before the packet is abandoned.

Ports:
- `eth_tx_clk`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `send_req`  in  1  one-cycle pulse requesting a read-back packet (typically `rec_pkt_done`)
- `wave_select`  in  4  current waveform select
- `amp_ctl`  in  9  current amplitude
- `freq_ctl`  in  32  current frequency word
- `min_ctl`  in  32  current minimum-resolution word
- `phase_ctl`  in  12  current phase
- `tx_req`  in  1  UDP core requests the next 32-bit word
- `tx_done`  in  1  UDP core finished sending the packet
- `tx_start_en`  out  1  one-cycle packet start pulse to the UDP core
- `tx_byte_num`  out  16  packet payload length in bytes
- `tx_data`  out  32  payload word; bits [31:24] are the first byte on the wire
- `busy`  out  1  high from trigger accept until return to IDLE
- `timeout_err`  out  1  one-cycle pulse when a packet is abandoned

## Operation
- States: IDLE, START, SEND, WAIT_DONE.
- **IDLE**
  - When `send_req` or `pending` is set, snapshot all five config inputs, clear `pending`, set `busy`, and go to START.
- **START**
  - Drive `tx_start_en` = 1 for exactly this cycle.
  - Load `tx_byte_num` = 24 and clear the word index.
  - Go to SEND.
- **SEND**
  - Each `tx_req` loads `tx_data` with word[idx], then increments idx.
  - Payload words:
    - word0 = {28'b0, wave}
    - word1 = {23'b0, amp}
    - word2 = freq
    - word3 = min
    - word4 = {20'b0, phase}
    - word5 = {16'hA55A, seq[15:0]}
  - The `tx_req` that loads word5 moves the block to WAIT_DONE.
- **WAIT_DONE**
  - On `tx_done`: increment `seq` (16-bit, wraps 0xFFFF→0), clear `busy`, go to IDLE.
- **Watchdog**
  - Counts in SEND and WAIT_DONE; cleared on entry to START and on every `tx_req`.
  - On reaching `TIMEOUT_CYC`: pulse `timeout_err`, go to IDLE, leave `seq` unchanged.
- **Boundary cases**
  - `send_req` while `busy` sets `pending`. At most one request is queued; further requests merge into it.
  - `send_req` in the same cycle as `tx_done` sets `pending`. The next packet then starts from IDLE one cycle later.
  - `tx_req` after word5 (in WAIT_DONE) loads `tx_data` = 0 and does not change state.
  - `tx_done` in SEND before six words: treated as completion (`seq`++, IDLE).
  - Config inputs changing mid-packet do not affect the packet being sent; only the snapshot is transmitted.
  - Reset mid-packet aborts immediately and drops `pending`.

## Timing
- Reset values:
  - `tx_start_en`, `busy`, `timeout_err` = 0
  - `tx_data` = 0, `tx_byte_num` = 0
  - `seq` = 0, `pending` = 0
  - state IDLE; snapshot registers = 0
- `send_req` in cycle n (IDLE):
  - `busy` = 1 in n+1
  - `tx_start_en` = 1 in n+2
- `tx_req` in cycle m: the corresponding word is valid on `tx_data` in m+1 and held until the next `tx_req`.
- `tx_done` in cycle k: `busy` = 0 in k+1; a pending packet's `tx_start_en` follows in k+3.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `eth_dds_pkg`:
  - `DDS_WORD_NUM` = 6, `DDS_BYTE_NUM` = 24, `DDS_MAGIC` = 16'hA55A
  - state enum
  - also used by the receiver for word offsets
- No sub-module; the word mux is a local function of idx.

## Test plan
- Reset, then `send_req` with wave=2, amp=256, freq=3615292, min=0, phase=1024; `tx_req` every 4 cycles, `tx_done` 10 cycles after the last word -> one `tx_start_en`, `tx_byte_num` = 24, `tx_data` sequence 2, 256, 3615292, 0, 1024, 0xA55A0000; `busy` falls after `tx_done`.
- Three `send_req` pulses during one packet -> exactly one extra packet, with word5 = 0xA55A0001.
- Change `freq_ctl` to 1000 after `tx_start_en` -> word2 still 3615292; the next packet carries 1000.
- No `tx_req` after start, `TIMEOUT_CYC` = 100 -> `timeout_err` pulse 100 cycles after START, IDLE, next packet `seq` unchanged.
- Force `seq` = 0xFFFF, complete a packet -> word5 = 0xA55AFFFF; the next packet's word5 = 0xA55A0000.
- Assert `rst_n` low after word2 -> all outputs return to reset values, `pending` cleared, no `tx_start_en` after reset release.
